// File: rtl/cpu_pkg.sv
// cpu_pkg: shared word width and demux channel select encoding
package cpu_pkg;
  localparam int WORD_W = 32;
  typedef enum logic {CH0 = 1'b0, CH1 = 1'b1} ch_e;
endpackage

// File: rtl/sync_fifo_32.sv
// sync_fifo_32: single-clock FIFO with level counter, registered head output and sync clear
module sync_fifo_32 #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CNTW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CNTW-1:0]  level
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  always_comb begin
    empty   = level == '0;
    full    = level == CNTW'(DEPTH);
    do_push = push & !full;
    do_pop  = pop & !empty;
    dout    = mem[rd_ptr];
  end
  // clr keeps storage contents; only pointers and level return to zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) mem[wr_ptr] <= din;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + CNTW'(do_push) - CNTW'(do_pop);
    end
endmodule

// File: rtl/demux2_32_buf.sv
// demux2_32_buf: 1:2 buffered word demultiplexer with an independent FIFO per channel
module demux2_32_buf import cpu_pkg::*; #(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 4,
  localparam int CNTW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNTW-1:0]  out0_level,
  output logic [CNTW-1:0]  out1_level
);
  logic empty0, empty1, full0, full1, push0, push1;
  // full is registered, so a same-cycle pop never reopens a full channel
  always_comb begin
    in_ready   = !flush & (in_sel == CH1 ? !full1 : !full0);
    push0      = in_valid & in_ready & (in_sel == CH0);
    push1      = in_valid & in_ready & (in_sel == CH1);
    out0_valid = !empty0;
    out1_valid = !empty1;
  end
  sync_fifo_32 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk(clk), .rst_n(rst_n), .clr(flush), .push(push0), .din(in_data),
    .pop(out0_valid & out0_ready), .dout(out0_data), .empty(empty0), .full(full0),
    .level(out0_level)
  );
  sync_fifo_32 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk(clk), .rst_n(rst_n), .clr(flush), .push(push1), .din(in_data),
    .pop(out1_valid & out1_ready), .dout(out1_data), .empty(empty1), .full(full1),
    .level(out1_level)
  );
endmodule

// File: tb/tb_demux2_32_buf.sv
// tb_demux2_32_buf: directed self-checking bench for the 1:2 buffered demux
module tb_demux2_32_buf;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, in_sel = 0;
  logic [31:0] in_data = '0;
  logic out0_ready = 0, out1_ready = 0;
  logic in_ready, out0_valid, out1_valid;
  logic [31:0] out0_data, out1_data;
  logic [2:0] out0_level, out1_level;
  int n_cmp = 0, n_bad = 0;

  demux2_32_buf dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_data(in_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out0_data(out0_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .out1_data(out1_data), .out0_level(out0_level), .out1_level(out1_level)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if ({out0_valid, out1_valid} !== 2'b00) begin n_bad++; $display("FAIL reset_valid got %b want 00", {out0_valid, out1_valid}); end
    n_cmp++; if ({out0_level, out1_level} !== 6'd0) begin n_bad++; $display("FAIL reset_level got %0d/%0d want 0/0", out0_level, out1_level); end
    n_cmp++; if ({out0_data, out1_data} !== 64'd0) begin n_bad++; $display("FAIL reset_data got %h/%h want 0/0", out0_data, out1_data); end
    #2 rst_n = 1;
    tick;
  endtask

  task automatic test_steering;
    out0_ready = 1; out1_ready = 1;
    in_valid = 1; in_sel = 0; in_data = 32'hA000_0001;
    tick;
    n_cmp++; if (out0_valid !== 1'b1 || out0_data !== 32'hA000_0001) begin n_bad++; $display("FAIL steer_ch0 got v=%b d=%h want v=1 d=a0000001", out0_valid, out0_data); end
    n_cmp++; if (out1_valid !== 1'b0) begin n_bad++; $display("FAIL steer_ch1_idle got v=%b want 0", out1_valid); end
    in_sel = 1; in_data = 32'hB000_0002;
    tick;
    in_valid = 0;
    n_cmp++; if (out1_valid !== 1'b1 || out1_data !== 32'hB000_0002) begin n_bad++; $display("FAIL steer_ch1 got v=%b d=%h want v=1 d=b0000002", out1_valid, out1_data); end
    n_cmp++; if (out0_valid !== 1'b0 || out0_level !== 3'd0) begin n_bad++; $display("FAIL steer_ch0_pop got v=%b l=%0d want v=0 l=0", out0_valid, out0_level); end
    tick;
    n_cmp++; if (out1_level !== 3'd0) begin n_bad++; $display("FAIL steer_ch1_pop got %0d want 0", out1_level); end
  endtask

  task automatic test_backpressure;
    out0_ready = 0; out1_ready = 0;
    in_valid = 1; in_sel = 0;
    for (int i = 1; i <= 4; i++) begin
      in_data = 32'(i);
      tick;
    end
    n_cmp++; if (out0_level !== 3'd4 || out0_data !== 32'd1) begin n_bad++; $display("FAIL bp_level got l=%0d d=%h want l=4 d=1", out0_level, out0_data); end
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_sel0 got %b want 0", in_ready); end
    in_sel = 1; in_data = 32'hC3;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_sel1 got %b want 1", in_ready); end
    tick;
    in_valid = 0;
    n_cmp++; if (out1_valid !== 1'b1 || out1_data !== 32'hC3 || out0_level !== 3'd4) begin n_bad++; $display("FAIL bp_ch1 got v=%b d=%h l0=%0d want v=1 d=c3 l0=4", out1_valid, out1_data, out0_level); end
    out1_ready = 1;
    tick;
    n_cmp++; if (out1_valid !== 1'b0) begin n_bad++; $display("FAIL bp_ch1_drain got %b want 0", out1_valid); end
  endtask

  task automatic test_full_pop;
    out0_ready = 1; in_valid = 1; in_sel = 0; in_data = 32'h99;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL fullpop_ready got %b want 0", in_ready); end
    tick;
    n_cmp++; if (out0_level !== 3'd3 || out0_data !== 32'd2) begin n_bad++; $display("FAIL fullpop_level got l=%0d d=%h want l=3 d=2", out0_level, out0_data); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL fullpop_reopen got %b want 1", in_ready); end
    in_valid = 0;
    repeat (3) tick;
    n_cmp++; if (out0_level !== 3'd0 || out0_valid !== 1'b0) begin n_bad++; $display("FAIL fullpop_drain got l=%0d v=%b want 0/0", out0_level, out0_valid); end
  endtask

  task automatic test_wrap_order;
    int pushed = 0, got = 0;
    in_sel = 0;
    for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
      out0_ready = cyc[0];
      in_valid = pushed < 10;
      in_data = 32'h10 + 32'(pushed);
      #1;
      if (out0_valid && out0_ready) begin
        n_cmp++; if (out0_data !== 32'h10 + 32'(got)) begin n_bad++; $display("FAIL wrap_word%0d got %h want %h", got, out0_data, 32'h10 + 32'(got)); end
        got++;
      end
      if (in_valid && in_ready) pushed++;
      tick;
    end
    in_valid = 0; out0_ready = 0;
    n_cmp++; if (got !== 10 || out0_level !== 3'd0) begin n_bad++; $display("FAIL wrap_count got %0d words l=%0d want 10 l=0", got, out0_level); end
  endtask

  task automatic load_two_each;
    out0_ready = 0; out1_ready = 0; in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      in_sel = i[1]; in_data = 32'h50 + 32'(i);
      tick;
    end
    in_valid = 0;
  endtask

  task automatic test_flush_reset;
    load_two_each;
    n_cmp++; if (out0_level !== 3'd2 || out1_level !== 3'd2) begin n_bad++; $display("FAIL flush_load got %0d/%0d want 2/2", out0_level, out1_level); end
    flush = 1; in_valid = 1; in_sel = 0; in_data = 32'hEE;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready got %b want 0", in_ready); end
    tick;
    flush = 0; in_valid = 0;
    n_cmp++; if ({out0_level, out1_level} !== 6'd0 || {out0_valid, out1_valid} !== 2'b00) begin n_bad++; $display("FAIL flush_clear got l=%0d/%0d v=%b want 0/0 v=00", out0_level, out1_level, {out0_valid, out1_valid}); end
    load_two_each;
    #2 rst_n = 0;
    #1;
    n_cmp++; if ({out0_valid, out1_valid} !== 2'b00 || {out0_level, out1_level} !== 6'd0) begin n_bad++; $display("FAIL async_rst got v=%b l=%0d/%0d want 00 0/0", {out0_valid, out1_valid}, out0_level, out1_level); end
    n_cmp++; if ({out0_data, out1_data} !== 64'd0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL async_rst_data got %h/%h r=%b want 0/0 r=1", out0_data, out1_data, in_ready); end
    #1 rst_n = 1;
    tick;
  endtask

  initial begin
    test_reset;
    test_steering;
    test_backpressure;
    test_full_pop;
    test_wrap_order;
    test_flush_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
